wb_port_arbiter: RTL and testbench

- Shares the two physical-register-file write ports among the four execution units: alu, sfu, bru and agu.
- Sits between the execute stage and the PRF/ROB writeback interface.
- Selects up to two results per cycle using round-robin priority.
- Parks each losing result in a per-unit one-entry holding buffer and back-pressures that unit with a ready signal.
- Write-port outputs are registered.

---
 rtl/wb_port_arbiter_if.sv | 31 +++
 rtl/wb_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// Writeback bus between the execute units, the arbiter and the PRF write ports.
interface wb_port_arbiter_if #(
  parameter int DW = 32,
  parameter int PW = 6
) ();
  logic          aluen, sfuen, bruen, aguen;
  logic [PW-1:0] alurd, sfurd, brurd, agurd;
  logic [DW-1:0] aluout, sfuout, bruout, aguout;
  logic          alurdy, sfurdy, brurdy, agurdy;
  logic          wp0_en, wp1_en;
  logic [PW-1:0] wp0_rd, wp1_rd;
  logic [DW-1:0] wp0_data, wp1_data;

  modport master (
    output aluen, sfuen, bruen, aguen,
    output alurd, sfurd, brurd, agurd,
    output aluout, sfuout, bruout, aguout,
    input  alurdy, sfurdy, brurdy, agurdy,
    input  wp0_en, wp1_en, wp0_rd, wp1_rd,
    input  wp0_data, wp1_data
  );

  modport slave (
    input  aluen, sfuen, bruen, aguen,
    input  alurd, sfurd, brurd, agurd,
    input  aluout, sfuout, bruout, aguout,
    output alurdy, sfurdy, brurdy, agurdy,
    output wp0_en, wp1_en, wp0_rd, wp1_rd,
    output wp0_data, wp1_data
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing two PRF write ports among alu/sfu/bru/agu.
// WB_PERF_CNT_EN builds the saturating stall-cycle counter.
module wb_port_arbiter #(
  parameter int DW = 32,
  parameter int PW = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  wb_port_arbiter_if.slave bus,
  output logic [15:0] conflict_cnt
);
  logic [3:0]    en;
  logic [PW-1:0] rd_in [4];
  logic [DW-1:0] dat_in [4];

  logic [3:0]    buf_full_q, buf_full_d;
  logic [PW-1:0] buf_rd_q [4];
  logic [PW-1:0] buf_rd_d [4];
  logic [DW-1:0] buf_dat_q [4];
  logic [DW-1:0] buf_dat_d [4];
  logic [1:0]    rr_q, rr_d;

  logic          wp0_en_q, wp0_en_d;
  logic          wp1_en_q, wp1_en_d;
  logic [PW-1:0] wp0_rd_q, wp0_rd_d;
  logic [PW-1:0] wp1_rd_q, wp1_rd_d;
  logic [DW-1:0] wp0_dat_q, wp0_dat_d;
  logic [DW-1:0] wp1_dat_q, wp1_dat_d;

  logic [3:0]    cand_v;
  logic [PW-1:0] cand_rd [4];
  logic [DW-1:0] cand_dat [4];
  logic [3:0]    gnt;
  logic          g0_v, g1_v;
  logic [1:0]    g0_idx, g1_idx, last, idx;

  always_comb begin
    en = {bus.aguen, bus.bruen, bus.sfuen, bus.aluen};
    rd_in[0]  = bus.alurd;
    rd_in[1]  = bus.sfurd;
    rd_in[2]  = bus.brurd;
    rd_in[3]  = bus.agurd;
    dat_in[0] = bus.aluout;
    dat_in[1] = bus.sfuout;
    dat_in[2] = bus.bruout;
    dat_in[3] = bus.aguout;
  end

  // A full buffer shadows the input: rdy is low, so en is ignored.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cand_v[i]   = ~flush & (buf_full_q[i] | en[i]);
      cand_rd[i]  = buf_full_q[i] ? buf_rd_q[i] : rd_in[i];
      cand_dat[i] = buf_full_q[i] ? buf_dat_q[i] : dat_in[i];
    end
  end

  always_comb begin
    gnt    = '0;
    g0_v   = 1'b0;
    g1_v   = 1'b0;
    g0_idx = '0;
    g1_idx = '0;
    last   = rr_q;
    idx    = '0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_q + 2'(k);
      if (cand_v[idx] && !g1_v) begin
        gnt[idx] = 1'b1;
        last     = idx;
        if (!g0_v) begin
          g0_v   = 1'b1;
          g0_idx = idx;
        end else begin
          g1_v   = 1'b1;
          g1_idx = idx;
        end
      end
    end
  end

  always_comb begin
    buf_full_d = buf_full_q;
    buf_rd_d   = buf_rd_q;
    buf_dat_d  = buf_dat_q;
    rr_d       = g0_v ? last + 2'd1 : rr_q;
    wp0_en_d   = g0_v;
    wp1_en_d   = g1_v;
    wp0_rd_d   = g0_v ? cand_rd[g0_idx]  : wp0_rd_q;
    wp0_dat_d  = g0_v ? cand_dat[g0_idx] : wp0_dat_q;
    wp1_rd_d   = g1_v ? cand_rd[g1_idx]  : wp1_rd_q;
    wp1_dat_d  = g1_v ? cand_dat[g1_idx] : wp1_dat_q;
    if (flush) begin
      buf_full_d = '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (buf_full_q[i]) begin
          if (gnt[i]) buf_full_d[i] = 1'b0;
        end else if (en[i] && !gnt[i]) begin
          buf_full_d[i] = 1'b1;
          buf_rd_d[i]   = rd_in[i];
          buf_dat_d[i]  = dat_in[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_full_q <= '0;
      rr_q       <= '0;
      wp0_en_q   <= 1'b0;
      wp1_en_q   <= 1'b0;
      wp0_rd_q   <= '0;
      wp1_rd_q   <= '0;
      wp0_dat_q  <= '0;
      wp1_dat_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        buf_rd_q[i]  <= '0;
        buf_dat_q[i] <= '0;
      end
    end else begin
      buf_full_q <= buf_full_d;
      rr_q       <= rr_d;
      wp0_en_q   <= wp0_en_d;
      wp1_en_q   <= wp1_en_d;
      wp0_rd_q   <= wp0_rd_d;
      wp1_rd_q   <= wp1_rd_d;
      wp0_dat_q  <= wp0_dat_d;
      wp1_dat_q  <= wp1_dat_d;
      buf_rd_q   <= buf_rd_d;
      buf_dat_q  <= buf_dat_d;
    end
  end

  assign bus.alurdy   = ~buf_full_q[0];
  assign bus.sfurdy   = ~buf_full_q[1];
  assign bus.brurdy   = ~buf_full_q[2];
  assign bus.agurdy   = ~buf_full_q[3];
  assign bus.wp0_en   = wp0_en_q;
  assign bus.wp1_en   = wp1_en_q;
  assign bus.wp0_rd   = wp0_rd_q;
  assign bus.wp1_rd   = wp1_rd_q;
  assign bus.wp0_data = wp0_dat_q;
  assign bus.wp1_data = wp1_dat_q;

`ifdef WB_PERF_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (|buf_full_d && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign conflict_cnt = cnt_q;
`else
  assign conflict_cnt = '0;
`endif
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed scoreboard bench for wb_port_arbiter.
module tb_wb_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [15:0] conflict_cnt;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    string       tag;
    logic        en0;
    logic [5:0]  rd0;
    logic [31:0] d0;
    logic        en1;
    logic [5:0]  rd1;
    logic [31:0] d1;
    logic [3:0]  rdy;
  } exp_t;

  exp_t sb[$];

  wb_port_arbiter_if #(.DW(32), .PW(6)) bus ();

  wb_port_arbiter #(.DW(32), .PW(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .bus          (bus),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_u(input int u, input logic e, input logic [5:0] r,
                       input logic [31:0] d);
    case (u)
      0: begin bus.aluen = e; bus.alurd = r; bus.aluout = d; end
      1: begin bus.sfuen = e; bus.sfurd = r; bus.sfuout = d; end
      2: begin bus.bruen = e; bus.brurd = r; bus.bruout = d; end
      default: begin bus.aguen = e; bus.agurd = r; bus.aguout = d; end
    endcase
  endtask

  task automatic idle();
    for (int u = 0; u < 4; u++) set_u(u, 1'b0, 6'd0, 32'd0);
  endtask

  task automatic all4(input logic [31:0] base);
    set_u(0, 1'b1, 6'd2, base + 1);
    set_u(1, 1'b1, 6'd3, base + 2);
    set_u(2, 1'b1, 6'd4, base + 3);
    set_u(3, 1'b1, 6'd7, base + 4);
  endtask

  task automatic step(input string tag,
                      input logic e0, input logic [5:0] r0, input logic [31:0] d0,
                      input logic e1, input logic [5:0] r1, input logic [31:0] d1,
                      input logic [3:0] rdy);
    exp_t x;
    exp_t y;
    x = '{tag, e0, r0, d0, e1, r1, d1, rdy};
    sb.push_back(x);
    @(posedge clk);
    #1;
    y = sb.pop_front();
    chk({y.tag, ".wp0_en"}, 32'(bus.wp0_en), 32'(y.en0));
    chk({y.tag, ".wp0_rd"}, 32'(bus.wp0_rd), 32'(y.rd0));
    chk({y.tag, ".wp0_data"}, bus.wp0_data, y.d0);
    chk({y.tag, ".wp1_en"}, 32'(bus.wp1_en), 32'(y.en1));
    chk({y.tag, ".wp1_rd"}, 32'(bus.wp1_rd), 32'(y.rd1));
    chk({y.tag, ".wp1_data"}, bus.wp1_data, y.d1);
    chk({y.tag, ".rdy"},
        32'({bus.agurdy, bus.brurdy, bus.sfurdy, bus.alurdy}), 32'(y.rdy));
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    all4(32'h100);
    step("rst", 0, 0, 0, 0, 0, 0, 4'hF);
    chk("rst.cnt", 32'(conflict_cnt), 32'd0);
    rst = 1'b0;
    idle();
    step("idle", 0, 0, 0, 0, 0, 0, 4'hF);

    set_u(0, 1'b1, 6'd5, 32'h11);
    set_u(2, 1'b1, 6'd9, 32'h22);
    step("alu_bru", 1, 5, 32'h11, 1, 9, 32'h22, 4'hF);

    idle();
    set_u(3, 1'b1, 6'h0a, 32'h33);
    set_u(0, 1'b1, 6'h0b, 32'h44);
    set_u(1, 1'b1, 6'h0c, 32'h55);
    step("wrap", 1, 6'h0a, 32'h33, 1, 6'h0b, 32'h44, 4'b1101);
    idle();
    step("drain_sfu", 1, 6'h0c, 32'h55, 0, 6'h0b, 32'h44, 4'hF);
    set_u(3, 1'b1, 6'd1, 32'h66);
    step("agu_only", 1, 1, 32'h66, 0, 6'h0b, 32'h44, 4'hF);

    all4(32'ha0);
    step("all4_c1", 1, 2, 32'ha1, 1, 3, 32'ha2, 4'b0011);
    idle();
    step("all4_c2", 1, 4, 32'ha3, 1, 7, 32'ha4, 4'hF);

    all4(32'hb0);
    step("refill", 1, 2, 32'hb1, 1, 3, 32'hb2, 4'b0011);
    idle();
    flush = 1'b1;
    set_u(0, 1'b1, 6'd8, 32'hc1);
    step("flush", 0, 2, 32'hb1, 0, 3, 32'hb2, 4'hF);
    flush = 1'b0;
    idle();
    set_u(0, 1'b1, 6'd5, 32'hd1);
    set_u(2, 1'b1, 6'd6, 32'hd2);
    step("post_flush", 1, 6, 32'hd2, 1, 5, 32'hd1, 4'hF);

    set_u(0, 1'b1, 6'h0a, 32'he1);
    set_u(1, 1'b1, 6'h0b, 32'he2);
    set_u(2, 1'b1, 6'h0c, 32'he3);
    set_u(3, 1'b1, 6'h0d, 32'he4);
    step("rr1_all4", 1, 6'h0b, 32'he2, 1, 6'h0c, 32'he3, 4'b0110);
    idle();
    rst = 1'b1;
    step("mid_rst", 0, 0, 0, 0, 0, 0, 4'hF);
    chk("mid_rst.cnt", 32'(conflict_cnt), 32'd0);
    rst = 1'b0;
    step("after_rst", 0, 0, 0, 0, 0, 0, 4'hF);

    all4(32'hf0);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
    end
    idle();
`ifdef WB_PERF_CNT_EN
    chk("perf.cnt", 32'(conflict_cnt), 32'd10);
`else
    chk("perf.cnt", 32'(conflict_cnt), 32'd0);
`endif
    chk("sb.empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
